// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: flushes, drives the single CSR write port, then redirects the PC.
// Optional CSR-ack watchdog enabled by defining TRAP_SEQ_WATCHDOG_EN.
module trap_sequencer #(
   parameter int XLEN       = 64,
   parameter int WDOG_LIMIT = 16
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            TRAP_REQ,
   input  logic [XLEN-1:0] TRAP_CAUSE,
   input  logic [XLEN-1:0] TRAP_PC,
   input  logic [XLEN-1:0] TRAP_TVAL,
   input  logic            MRET_REQ,
   input  logic [XLEN-1:0] MTVEC,
   input  logic [XLEN-1:0] MEPC,
   input  logic [XLEN-1:0] MSTATUS,
   input  logic            CSR_WACK,
   output logic            CSR_WE,
   output logic [11:0]     CSR_WADDR,
   output logic [XLEN-1:0] CSR_WDATA,
   output logic            FLUSH,
   output logic            WB_STALL,
   output logic            PC_MUX,
   output logic [XLEN-1:0] TARGET,
   output logic            BUSY,
   output logic            WDOG_ERR
);

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;

   if (WDOG_LIMIT < 1) begin : g_bad_wdog_limit
      $error("trap_sequencer: WDOG_LIMIT must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_W_MEPC,
      S_W_MCAUSE,
      S_W_MTVAL,
      S_W_MSTATUS,
      S_R_MSTATUS,
      S_REDIRECT
   } state_t;

   state_t          state;
   state_t          state_nx;

   logic [XLEN-1:0] snap_cause;
   logic [XLEN-1:0] snap_pc;
   logic [XLEN-1:0] snap_tval;
   logic [XLEN-1:0] snap_mtvec;
   logic [XLEN-1:0] snap_mepc;
   logic [XLEN-1:0] snap_mstatus;
   logic            is_trap;
   logic [XLEN-1:0] target_q;

   logic            accept_trap;
   logic            accept_mret;
   logic            write_state;
   logic            wdog_hit;
   logic            load_target;
   logic            we;
   logic [11:0]     waddr;
   logic [XLEN-1:0] wdata;
   logic            flush;
   logic            pc_mux;
   logic            wdog_err;

   // Trap entry: MPIE <- MIE, MIE <- 0, MPP <- M.
   function automatic logic [XLEN-1:0] mstatus_on_trap(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] r;
      r        = ms;
      r[7]     = ms[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   // MRET: MIE <- MPIE, MPIE <- 1, MPP <- U.
   function automatic logic [XLEN-1:0] mstatus_on_mret(input logic [XLEN-1:0] ms);
      logic [XLEN-1:0] r;
      r        = ms;
      r[3]     = ms[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b00;
      return r;
   endfunction

   // Only interrupts are vectored; exceptions always land on the base.
   function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] tvec,
                                                   input logic [XLEN-1:0] cause);
      logic [XLEN-1:0] base;
      base = tvec & ~XLEN'(3);
      if (tvec[1:0] == 2'b01 && cause[XLEN-1])
         return base + XLEN'({cause[5:0], 2'b00});
      return base;
   endfunction

   assign accept_trap = (state == S_IDLE) && TRAP_REQ;
   assign accept_mret = (state == S_IDLE) && !TRAP_REQ && MRET_REQ;
   assign write_state = (state == S_W_MEPC) || (state == S_W_MCAUSE) ||
                        (state == S_W_MTVAL) || (state == S_W_MSTATUS) ||
                        (state == S_R_MSTATUS);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= S_IDLE;
         snap_cause   <= '0;
         snap_pc      <= '0;
         snap_tval    <= '0;
         snap_mtvec   <= '0;
         snap_mepc    <= '0;
         snap_mstatus <= '0;
         is_trap      <= 1'b0;
         target_q     <= '0;
      end else begin
         state <= state_nx;
         if (accept_trap) begin
            snap_cause   <= TRAP_CAUSE;
            snap_pc      <= TRAP_PC;
            snap_tval    <= TRAP_TVAL;
            snap_mtvec   <= MTVEC;
            snap_mstatus <= MSTATUS;
            is_trap      <= 1'b1;
         end else if (accept_mret) begin
            snap_mepc    <= MEPC;
            snap_mstatus <= MSTATUS;
            is_trap      <= 1'b0;
         end
         if (load_target)
            target_q <= is_trap ? trap_target(snap_mtvec, snap_cause)
                                : (snap_mepc & ~XLEN'(1));
      end
   end

`ifdef TRAP_SEQ_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
   logic [WDOG_W-1:0] wdog_cnt;

   // Restarts on every state change, so each write state gets a fresh budget.
   always_ff @(posedge CLK) begin
      if (RESET || (state_nx != state))
         wdog_cnt <= '0;
      else if (write_state && !CSR_WACK)
         wdog_cnt <= wdog_cnt + WDOG_W'(1);
   end

   assign wdog_hit = write_state && (wdog_cnt == WDOG_W'(WDOG_LIMIT));
`else
   assign wdog_hit = 1'b0;
`endif

   always_comb begin
      state_nx    = state;
      we          = 1'b0;
      waddr       = '0;
      wdata       = '0;
      flush       = 1'b0;
      pc_mux      = 1'b0;
      wdog_err    = 1'b0;
      load_target = 1'b0;
      case (state)
         S_IDLE: begin
            if (TRAP_REQ || MRET_REQ)
               state_nx = S_FLUSH;
         end
         S_FLUSH: begin
            flush    = 1'b1;
            state_nx = is_trap ? S_W_MEPC : S_R_MSTATUS;
         end
         S_W_MEPC: begin
            we    = 1'b1;
            waddr = ADDR_MEPC;
            wdata = snap_pc & ~XLEN'(3);
            if (CSR_WACK)
               state_nx = S_W_MCAUSE;
         end
         S_W_MCAUSE: begin
            we    = 1'b1;
            waddr = ADDR_MCAUSE;
            wdata = snap_cause;
            if (CSR_WACK)
               state_nx = S_W_MTVAL;
         end
         S_W_MTVAL: begin
            we    = 1'b1;
            waddr = ADDR_MTVAL;
            wdata = snap_tval;
            if (CSR_WACK)
               state_nx = S_W_MSTATUS;
         end
         S_W_MSTATUS: begin
            we    = 1'b1;
            waddr = ADDR_MSTATUS;
            wdata = mstatus_on_trap(snap_mstatus);
            if (CSR_WACK) begin
               state_nx    = S_REDIRECT;
               load_target = 1'b1;
            end
         end
         S_R_MSTATUS: begin
            we    = 1'b1;
            waddr = ADDR_MSTATUS;
            wdata = mstatus_on_mret(snap_mstatus);
            if (CSR_WACK) begin
               state_nx    = S_REDIRECT;
               load_target = 1'b1;
            end
         end
         S_REDIRECT: begin
            pc_mux   = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase

      // A timed-out write abandons the sequence without redirecting.
      if (wdog_hit) begin
         we          = 1'b0;
         waddr       = '0;
         wdata       = '0;
         wdog_err    = 1'b1;
         load_target = 1'b0;
         state_nx    = S_IDLE;
      end
   end

   assign CSR_WE    = we;
   assign CSR_WADDR = waddr;
   assign CSR_WDATA = wdata;
   assign FLUSH     = flush;
   assign PC_MUX    = pc_mux;
   assign WDOG_ERR  = wdog_err;
   assign TARGET    = target_q;
   assign BUSY      = (state != S_IDLE);
   assign WB_STALL  = (state != S_IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed spec scenarios plus randomized sequences against a timeline model.
module tb_trap_sequencer;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        TRAP_REQ;
   logic [63:0] TRAP_CAUSE;
   logic [63:0] TRAP_PC;
   logic [63:0] TRAP_TVAL;
   logic        MRET_REQ;
   logic [63:0] MTVEC;
   logic [63:0] MEPC;
   logic [63:0] MSTATUS;
   logic        CSR_WACK;
   logic        CSR_WE;
   logic [11:0] CSR_WADDR;
   logic [63:0] CSR_WDATA;
   logic        FLUSH;
   logic        WB_STALL;
   logic        PC_MUX;
   logic [63:0] TARGET;
   logic        BUSY;
   logic        WDOG_ERR;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] last_target = '0;

   always #5 CLK = ~CLK;

   trap_sequencer #(.XLEN(64), .WDOG_LIMIT(16)) dut (
      .CLK(CLK), .RESET(RESET), .TRAP_REQ(TRAP_REQ), .TRAP_CAUSE(TRAP_CAUSE),
      .TRAP_PC(TRAP_PC), .TRAP_TVAL(TRAP_TVAL), .MRET_REQ(MRET_REQ), .MTVEC(MTVEC),
      .MEPC(MEPC), .MSTATUS(MSTATUS), .CSR_WACK(CSR_WACK), .CSR_WE(CSR_WE),
      .CSR_WADDR(CSR_WADDR), .CSR_WDATA(CSR_WDATA), .FLUSH(FLUSH), .WB_STALL(WB_STALL),
      .PC_MUX(PC_MUX), .TARGET(TARGET), .BUSY(BUSY), .WDOG_ERR(WDOG_ERR)
   );

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [63:0] ms_trap(input logic [63:0] ms);
      return (ms & ~64'h1888) | ((ms & 64'h8) << 4) | 64'h1800;
   endfunction

   function automatic logic [63:0] ms_mret(input logic [63:0] ms);
      return (ms & ~64'h1888) | ((ms & 64'h80) >> 4) | 64'h80;
   endfunction

   // Builds the expected cycle-by-cycle timeline of one request, drives it, and checks every cycle.
   task automatic run_seq(input bit trap, input bit both,
                          input logic [63:0] cause, pc, tval, mtvec, mepc, mstatus,
                          input int st0, st1, st2, st3,
                          output int pc_cyc, output logic [63:0] tgt_seen,
                          output logic [63:0] ms_seen);
      logic [11:0] wa [0:3];
      logic [63:0] wd [0:3];
      int          st [0:3];
      bit          e_we [0:63];
      bit          e_flush [0:63];
      bit          e_pc [0:63];
      bit          e_ack [0:63];
      logic [11:0] e_addr [0:63];
      logic [63:0] e_data [0:63];
      int          nw;
      int          pos;
      int          n;
      logic [63:0] exp_tgt;
      logic [63:0] base;
      logic [63:0] exp_t;
      logic [4:0]  got_ctl;
      logic [4:0]  exp_ctl;
      logic [76:0] got_csr;
      logic [76:0] exp_csr;
      for (int i = 0; i < 64; i++) begin
         e_we[i] = 0; e_flush[i] = 0; e_pc[i] = 0; e_ack[i] = 0;
         e_addr[i] = '0; e_data[i] = '0;
      end
      st[0] = st0; st[1] = st1; st[2] = st2; st[3] = st3;
      if (trap) begin
         nw = 4;
         wa[0] = 12'h341; wd[0] = pc & ~64'h3;
         wa[1] = 12'h342; wd[1] = cause;
         wa[2] = 12'h343; wd[2] = tval;
         wa[3] = 12'h300; wd[3] = ms_trap(mstatus);
         base = mtvec & ~64'h3;
         exp_tgt = ((mtvec % 4) == 1 && cause[63]) ? base + 4 * (cause % 64) : base;
      end else begin
         nw = 1;
         wa[0] = 12'h300; wd[0] = ms_mret(mstatus);
         wa[1] = '0; wd[1] = '0; wa[2] = '0; wd[2] = '0; wa[3] = '0; wd[3] = '0;
         exp_tgt = mepc & ~64'h1;
      end
      e_flush[1] = 1;
      pos = 2;
      for (int k = 0; k < nw; k++) begin
         for (int s = 0; s <= st[k]; s++) begin
            e_we[pos] = 1; e_addr[pos] = wa[k]; e_data[pos] = wd[k];
            e_ack[pos] = (s == st[k]);
            pos++;
         end
      end
      e_pc[pos] = 1;
      n = pos;

      @(posedge CLK); #1;
      TRAP_REQ = trap; MRET_REQ = trap ? both : 1'b1;
      TRAP_CAUSE = cause; TRAP_PC = pc; TRAP_TVAL = tval;
      MTVEC = mtvec; MEPC = mepc; MSTATUS = mstatus;
      CSR_WACK = 1'($urandom_range(0, 1));
      @(negedge CLK);
      checks++;
      if ({BUSY, CSR_WE, FLUSH, PC_MUX} !== 4'b0000) begin
         errors++;
         $display("FAIL idle_before_accept got busy/we/flush/pcmux=%b expected 0000",
                  {BUSY, CSR_WE, FLUSH, PC_MUX});
      end
      checks++;
      if (TARGET !== last_target) begin
         errors++;
         $display("FAIL target_held_idle got %h expected %h", TARGET, last_target);
      end

      pc_cyc = -1; tgt_seen = '0; ms_seen = '0;
      for (int c = 1; c <= n; c++) begin
         @(posedge CLK); #1;
         TRAP_REQ = 1'($urandom_range(0, 1)); MRET_REQ = 1'($urandom_range(0, 1));
         TRAP_CAUSE = rnd64(); TRAP_PC = rnd64(); TRAP_TVAL = rnd64();
         MTVEC = rnd64(); MEPC = rnd64(); MSTATUS = rnd64();
         CSR_WACK = e_we[c] ? e_ack[c] : 1'($urandom_range(0, 1));
         @(negedge CLK);
         got_ctl = {FLUSH, PC_MUX, BUSY, WB_STALL, WDOG_ERR};
         exp_ctl = {e_flush[c], e_pc[c], 1'b1, 1'b1, 1'b0};
         checks++;
         if (got_ctl !== exp_ctl) begin
            errors++;
            $display("FAIL ctl cycle %0d got flush/pcmux/busy/stall/wdog=%b expected %b",
                     c, got_ctl, exp_ctl);
         end
         got_csr = {CSR_WE, CSR_WADDR, CSR_WDATA};
         exp_csr = e_we[c] ? {1'b1, e_addr[c], e_data[c]} : 77'd0;
         checks++;
         if (got_csr !== exp_csr) begin
            errors++;
            $display("FAIL csr cycle %0d got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                     c, CSR_WE, CSR_WADDR, CSR_WDATA, e_we[c], e_addr[c], e_data[c]);
         end
         exp_t = (c == n) ? exp_tgt : last_target;
         checks++;
         if (TARGET !== exp_t) begin
            errors++;
            $display("FAIL target cycle %0d got %h expected %h", c, TARGET, exp_t);
         end
         if (PC_MUX === 1'b1 && pc_cyc < 0) begin
            pc_cyc = c; tgt_seen = TARGET;
         end
         if (CSR_WE === 1'b1 && CSR_WADDR === 12'h300 && CSR_WACK === 1'b1)
            ms_seen = CSR_WDATA;
      end
      last_target = exp_tgt;
      TRAP_REQ = 1'b0; MRET_REQ = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1; TRAP_REQ = 1'b1; MRET_REQ = 1'b1; CSR_WACK = 1'b1;
      TRAP_CAUSE = rnd64(); TRAP_PC = rnd64(); TRAP_TVAL = rnd64();
      MTVEC = rnd64(); MEPC = rnd64(); MSTATUS = rnd64();
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({CSR_WE, CSR_WADDR, CSR_WDATA, FLUSH, WB_STALL, PC_MUX, TARGET, BUSY, WDOG_ERR} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got we=%b addr=%h data=%h flush=%b stall=%b pcmux=%b target=%h busy=%b wdog=%b expected all 0",
                  CSR_WE, CSR_WADDR, CSR_WDATA, FLUSH, WB_STALL, PC_MUX, TARGET, BUSY, WDOG_ERR);
      end
      @(posedge CLK); #1;
      RESET = 1'b0; TRAP_REQ = 1'b0; MRET_REQ = 1'b0;
      @(negedge CLK);
      checks++;
      if ({BUSY, WB_STALL, FLUSH} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release_idle got busy/stall/flush=%b expected 000", {BUSY, WB_STALL, FLUSH});
      end
      last_target = '0;
   endtask

   task automatic test_trap_direct();
      int pc_cyc; logic [63:0] tgt; logic [63:0] ms;
      run_seq(1, 0, 64'd2, 64'h8000_0104, 64'h13, 64'h8000_0200, rnd64(), 64'h8,
              0, 0, 0, 0, pc_cyc, tgt, ms);
      checks++;
      if (pc_cyc !== 6) begin errors++; $display("FAIL trap_direct_latency got %0d expected 6", pc_cyc); end
      checks++;
      if (tgt !== 64'h8000_0200) begin errors++; $display("FAIL trap_direct_target got %h expected 80000200", tgt); end
      checks++;
      if (ms !== 64'h1880) begin errors++; $display("FAIL trap_direct_mstatus got %h expected 1880", ms); end
   endtask

   task automatic test_trap_vectored();
      int pc_cyc; logic [63:0] tgt; logic [63:0] ms;
      run_seq(1, 0, 64'h8000_0000_0000_0007, 64'h8000_0300, 64'h0, 64'h8000_0201, rnd64(), 64'h8,
              0, 0, 0, 0, pc_cyc, tgt, ms);
      checks++;
      if (tgt !== 64'h8000_021C) begin errors++; $display("FAIL trap_vectored_target got %h expected 8000021c", tgt); end
      checks++;
      if (ms[3] !== 1'b0) begin errors++; $display("FAIL trap_vectored_mie got %b expected 0", ms[3]); end
      run_seq(1, 0, 64'd5, 64'h8000_0400, 64'h44, 64'h8000_0201, rnd64(), 64'h0,
              0, 0, 0, 0, pc_cyc, tgt, ms);
      checks++;
      if (tgt !== 64'h8000_0200) begin errors++; $display("FAIL trap_vectored_exception_target got %h expected 80000200", tgt); end
   endtask

   task automatic test_mret();
      int pc_cyc; logic [63:0] tgt; logic [63:0] ms;
      run_seq(0, 0, rnd64(), rnd64(), rnd64(), rnd64(), 64'h8000_0108, 64'h1880,
              0, 0, 0, 0, pc_cyc, tgt, ms);
      checks++;
      if (pc_cyc !== 3) begin errors++; $display("FAIL mret_latency got %0d expected 3", pc_cyc); end
      checks++;
      if (tgt !== 64'h8000_0108) begin errors++; $display("FAIL mret_target got %h expected 80000108", tgt); end
      checks++;
      if (ms !== 64'h88) begin errors++; $display("FAIL mret_mstatus got %h expected 88", ms); end
   endtask

   task automatic test_simultaneous_backpressure();
      int pc_cyc; logic [63:0] tgt; logic [63:0] ms;
      run_seq(1, 1, 64'd11, 64'h8000_1000, 64'h0, 64'h8000_0200, 64'h8000_2000, 64'h88,
              0, 3, 0, 0, pc_cyc, tgt, ms);
      checks++;
      if (pc_cyc !== 9) begin errors++; $display("FAIL simul_latency got %0d expected 9", pc_cyc); end
      checks++;
      if (tgt !== 64'h8000_0200) begin errors++; $display("FAIL simul_trap_priority_target got %h expected 80000200", tgt); end
   endtask

   task automatic test_back_to_back();
      int pc_cyc; logic [63:0] tgt; logic [63:0] ms;
      run_seq(1, 0, 64'd3, 64'h8000_0010, 64'h0, 64'h8000_0100, rnd64(), 64'h0,
              0, 0, 0, 0, pc_cyc, tgt, ms);
      run_seq(0, 0, rnd64(), rnd64(), rnd64(), rnd64(), 64'h8000_0555, 64'h80,
              1, 0, 0, 0, pc_cyc, tgt, ms);
      checks++;
      if (pc_cyc !== 4) begin errors++; $display("FAIL b2b_mret_latency got %0d expected 4", pc_cyc); end
      checks++;
      if (tgt !== 64'h8000_0554) begin errors++; $display("FAIL b2b_mret_target got %h expected 80000554", tgt); end
   endtask

   task automatic test_reset_mid();
      int pc_cyc; logic [63:0] tgt; logic [63:0] ms;
      @(posedge CLK); #1;
      TRAP_REQ = 1'b1; MRET_REQ = 1'b0; CSR_WACK = 1'b1;
      TRAP_CAUSE = 64'd4; TRAP_PC = 64'h8000_0800; TRAP_TVAL = 64'h1234; MTVEC = 64'h8000_0900; MSTATUS = 64'h8;
      @(posedge CLK); #1;
      TRAP_REQ = 1'b0;
      repeat (3) begin @(posedge CLK); #1; end
      @(negedge CLK);
      checks++;
      if ({CSR_WE, CSR_WADDR} !== {1'b1, 12'h343}) begin
         errors++;
         $display("FAIL reset_mid_in_mtval got we=%b addr=%h expected we=1 addr=343", CSR_WE, CSR_WADDR);
      end
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
      @(negedge CLK);
      checks++;
      if ({CSR_WE, CSR_WADDR, CSR_WDATA, FLUSH, WB_STALL, PC_MUX, TARGET, BUSY, WDOG_ERR} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs got we=%b addr=%h data=%h flush=%b stall=%b pcmux=%b target=%h busy=%b expected all 0",
                  CSR_WE, CSR_WADDR, CSR_WDATA, FLUSH, WB_STALL, PC_MUX, TARGET, BUSY);
      end
      last_target = '0;
      run_seq(1, 0, 64'd8, 64'h8000_0a00, 64'h0, 64'h8000_0b00, rnd64(), 64'h0,
              0, 0, 0, 0, pc_cyc, tgt, ms);
      checks++;
      if (pc_cyc !== 6) begin errors++; $display("FAIL reset_mid_reaccept_latency got %0d expected 6", pc_cyc); end
   endtask

   task automatic test_random();
      int pc_cyc; logic [63:0] tgt; logic [63:0] ms;
      for (int i = 0; i < 24; i++) begin
         run_seq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rnd64(), rnd64(), rnd64(), rnd64(), rnd64(), rnd64(),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 pc_cyc, tgt, ms);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_trap_direct();
      test_trap_vectored();
      test_mret();
      test_simultaneous_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      @(posedge CLK); #1;
      TRAP_REQ = 1'b0; MRET_REQ = 1'b0;
      @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL final_idle got busy=%b expected 0", BUSY); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle controller that sequences machine-mode context switches for the writeback stage.
- On a trap request (cause/CS from the trap handler) it:
  - flushes the pipeline;
  - writes mepc, mcause, mtval and mstatus one at a time through the single CSR write port;
  - redirects the PC to the mtvec-derived handler address.
- On MRET it restores mstatus and redirects the PC to mepc.
- While busy it owns the CSR write port and stalls writeback.

Parameters:
- XLEN, 64, data/address width.
- WDOG_LIMIT, 16, maximum cycles to wait for CSR_WACK (used only with the optional feature).

Ports:
- CLK  in  1  core clock.
- RESET  in  1  synchronous, active-high reset.
- TRAP_REQ  in  1  trap pending (WB_CS); sampled only in IDLE.
- TRAP_CAUSE  in  XLEN  mcause value; bit XLEN-1 = interrupt.
- TRAP_PC  in  XLEN  PC of the trapping instruction.
- TRAP_TVAL  in  XLEN  faulting address or instruction bits.
- MRET_REQ  in  1  MRET retiring in writeback; sampled only in IDLE.
- MTVEC  in  XLEN  current mtvec.
- MEPC  in  XLEN  current mepc.
- MSTATUS  in  XLEN  current mstatus.
- CSR_WACK  in  1  CSR file accepted the write this cycle.
- CSR_WE  out  1  CSR write request.
- CSR_WADDR  out  12  CSR address.
- CSR_WDATA  out  XLEN  CSR write data.
- FLUSH  out  1  kill all younger pipeline stages.
- WB_STALL  out  1  hold writeback and block WB_ST_CSR.
- PC_MUX  out  1  select TARGET as next PC (one-cycle pulse).
- TARGET  out  XLEN  redirect address.
- BUSY  out  1  sequencer not in IDLE.
- WDOG_ERR  out  1  watchdog timeout pulse (tied 0 without the optional feature).

Behaviour:
- Reset:
  - State = IDLE.
  - All outputs 0; TARGET = 0.
  - Internal snapshot registers cleared.
- States: IDLE, FLUSH, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, R_MSTATUS, REDIRECT.
- IDLE:
  - TRAP_REQ=1 → FLUSH. Snapshot TRAP_CAUSE, TRAP_PC, TRAP_TVAL, MTVEC and MSTATUS in the same cycle.
  - Else MRET_REQ=1 → FLUSH. Snapshot MEPC and MSTATUS.
  - TRAP_REQ has priority when both are asserted.
- FLUSH:
  - FLUSH=1 for exactly one cycle.
  - Next state: W_MEPC (trap path) or R_MSTATUS (MRET path).
- CSR write states:
  - CSR_WE=1 with fixed address/data; state advances only on CSR_WACK=1.
  - W_MEPC: addr 0x341, data = {snap_pc[XLEN-1:2],2'b00}.
  - W_MCAUSE: addr 0x342, data = snap_cause.
  - W_MTVAL: addr 0x343, data = snap_tval.
  - W_MSTATUS (trap):
    - addr 0x300.
    - Data = snapshot mstatus with MPIE[7]←MIE[3], MIE[3]←0, MPP[12:11]←2'b11.
    - Next state: REDIRECT.
  - R_MSTATUS (MRET):
    - addr 0x300.
    - Data = snapshot mstatus with MIE[3]←MPIE[7], MPIE[7]←1, MPP[12:11]←2'b00.
    - Next state: REDIRECT.
- REDIRECT:
  - PC_MUX=1 for one cycle, then → IDLE.
  - TARGET registered on entry and held until the next REDIRECT.
  - Trap, direct mode: base = {snap_mtvec[XLEN-1:2],2'b00}.
  - Trap, vectored mode (mtvec[1:0]=01 and cause interrupt bit set): base + 4*cause[5:0].
  - Trap, vectored mode with an exception cause: base.
  - MRET: TARGET = {snap_mepc[XLEN-1:1],1'b0}.
- BUSY and WB_STALL = 1 in every state except IDLE.
- Latency with CSR_WACK tied high:
  - Trap: request accepted cycle 0, PC_MUX pulse at cycle 6.
  - MRET: PC_MUX pulse at cycle 3.
  - Each WACK-low cycle adds one cycle.
- Requests asserted while BUSY are ignored; upstream holds them.
- A request may be re-accepted in the cycle after REDIRECT.
- RESET mid-sequence:
  - Returns to IDLE immediately with all outputs cleared.
  - Already-acked CSR writes are not rolled back.
- CSR_WDATA/CSR_WADDR are 0 whenever CSR_WE=0.

Optional Feature:
- Macro: TRAP_SEQ_WATCHDOG_EN.
- Defined:
  - A counter resets on entry to each write state and increments each cycle CSR_WE=1 with CSR_WACK=0.
  - When the counter reaches WDOG_LIMIT: WDOG_ERR pulses for one cycle, CSR_WE drops, and the FSM goes to IDLE without redirect.
- Undefined: no counter; waits indefinitely; WDOG_ERR tied 0.

Test Plan:
- Trap, direct mode:
  - Stimulus: TRAP_REQ, cause=2, pc=0x8000_0104, tval=0x0000_0013, mtvec=0x8000_0200, mstatus=0x8, WACK=1.
  - Response: writes 0x341←0x8000_0104, 0x342←2, 0x343←0x13, 0x300←0x1880; PC_MUX at cycle 6 with TARGET=0x8000_0200.
- Trap, vectored mode:
  - Stimulus: cause=0x8000_0000_0000_0007, mtvec=0x8000_0201.
  - Response: TARGET=0x8000_021C; mstatus MIE cleared.
- MRET:
  - Stimulus: MRET_REQ, mepc=0x8000_0108, mstatus=0x1880.
  - Response: FLUSH at cycle 1; 0x300←0x88; PC_MUX at cycle 3 with TARGET=0x8000_0108.
- Simultaneous requests and back-pressure:
  - Stimulus: TRAP_REQ and MRET_REQ in the same cycle; WACK low for 3 cycles in W_MCAUSE.
  - Response: trap path taken; CSR_WE/address/data held stable; redirect at cycle 9; WB_STALL high throughout.
- Reset during W_MTVAL:
  - Response: next cycle all outputs 0 and BUSY=0; a new TRAP_REQ is accepted normally.
- With TRAP_SEQ_WATCHDOG_EN, WDOG_LIMIT=16, WACK stuck 0 in W_MEPC:
  - Response: WDOG_ERR pulse after 16 cycles, return to IDLE, no PC_MUX.
